// File: rtl/seg_number_gen.sv
// seg_number_gen: 3-bit digit counter for the seven-segment decoder, stepped by a
// prescaler in RUN or by a debounced step button in PAUSE; a debounced run button toggles mode.
module seg_number_gen #(
    parameter int DIV_CYCLES = 50_000_000,
    parameter int DB_CYCLES  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       sw_dir,
    output logic [2:0] number,
    output logic       running,
    output logic       step_o
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int PW = $clog2(DIV_CYCLES);
    typedef enum logic {PAUSE, RUN} state_t;
    state_t        state;
    logic [1:0]    btn, s1, s2, db, db_q;
    logic [DW-1:0] cnt [2];
    logic [PW-1:0] pre;
    logic          run_p, step_p, tick, step_ev;
    assign btn = {btn_step, btn_run};
    // Index 0 is the run button, index 1 the step button.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                s1[i]   <= 1'b0;
                s2[i]   <= 1'b0;
                db[i]   <= 1'b0;
                db_q[i] <= 1'b0;
                cnt[i]  <= '0;
            end else begin
                s1[i]   <= btn[i];
                s2[i]   <= s1[i];
                db_q[i] <= db[i];
                if (s2[i] == db[i])
                    cnt[i] <= '0;
                else if (cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else
                    cnt[i] <= cnt[i] + 1'b1;
            end
    end
    assign run_p   = db[0] & ~db_q[0];
    assign step_p  = db[1] & ~db_q[1];
    assign tick    = (state == RUN) && (pre == PW'(DIV_CYCLES - 1));
    assign step_ev = (state == RUN) ? tick : step_p;
    // The prescaler restarts on every mode change so RUN always begins a full period.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= PAUSE;
            running <= 1'b0;
            pre     <= '0;
            number  <= 3'd0;
            step_o  <= 1'b0;
        end else begin
            step_o <= step_ev;
            pre    <= (run_p || state == PAUSE || tick) ? '0 : pre + 1'b1;
            if (step_ev)
                number <= sw_dir ? number - 3'd1 : number + 3'd1;
            if (run_p) begin
                state   <= (state == RUN) ? PAUSE : RUN;
                running <= (state == PAUSE);
            end
        end
endmodule
